// File: rtl/sv_chan_gen.sv
// sv_chan_gen: GPS L1 C/A space-vehicle channel generator
//   (carrier NCO, code NCO, Gold code, nav-data modulation, gain scaling)
// Optional feature macro: SV_CHAN_GEN_NAV_EN (nav data modulation and bit handshake)
// Ports:
//   i_clk, i_reset                   clock, synchronous active-high reset
//   i_dv_in                          sample strobe; all sample state advances only when high
//   i_dop_freq                       carrier frequency word, two's complement
//   i_code_freq                      code NCO frequency word, unsigned
//   i_gain                           unsigned amplitude
//   i_ca_sel                         PRN 1..32, any other value mutes the channel
//   i_nav_bit, i_nav_valid           next navigation bit offer
//   o_nav_ready                      nav holding register empty
//   o_epoch_tick                     pulse with the first output sample of each code epoch
//   o_nav_underrun                   sticky: a bit boundary found the holding register empty
//   o_dv_out, o_real_out, o_imag_out output sample (three cycles after i_dv_in)
module sv_chan_gen #(
    parameter int PHASE_W = 32,
    parameter int NCO_W   = 6,
    parameter int GAIN_W  = 16,
    parameter int OUT_W   = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_dv_in,
    input  logic [PHASE_W-1:0]        i_dop_freq,
    input  logic [PHASE_W-1:0]        i_code_freq,
    input  logic [GAIN_W-1:0]         i_gain,
    input  logic [5:0]                i_ca_sel,
    input  logic                      i_nav_bit,
    input  logic                      i_nav_valid,
    output logic                      o_nav_ready,
    output logic                      o_epoch_tick,
    output logic                      o_nav_underrun,
    output logic                      o_dv_out,
    output logic signed [OUT_W-1:0]   o_real_out,
    output logic signed [OUT_W-1:0]   o_imag_out
);
    localparam int AMP    = 2**(NCO_W-1) - 1;
    localparam int PROD_W = NCO_W + GAIN_W + 1;
    // Octant samples sit at odd multiples of 22.5 degrees, so only two magnitudes exist
    localparam logic signed [NCO_W-1:0] W_C = NCO_W'($rtoi(AMP * 0.9238795325112867 + 0.5));
    localparam logic signed [NCO_W-1:0] W_S = NCO_W'($rtoi(AMP * 0.3826834323650898 + 0.5));

    function automatic logic [10:1] f_pair(input int a, input int b);
        f_pair = '0;
        f_pair[a] = 1'b1;
        f_pair[b] = 1'b1;
    endfunction

    // G2 tap pair per PRN; an all-zero mask marks an invalid selection
    function automatic logic [10:1] f_taps(input logic [5:0] prn);
        case (prn)
            6'd1:  f_taps = f_pair(2, 6);
            6'd2:  f_taps = f_pair(3, 7);
            6'd3:  f_taps = f_pair(4, 8);
            6'd4:  f_taps = f_pair(5, 9);
            6'd5:  f_taps = f_pair(1, 9);
            6'd6:  f_taps = f_pair(2, 10);
            6'd7:  f_taps = f_pair(1, 8);
            6'd8:  f_taps = f_pair(2, 9);
            6'd9:  f_taps = f_pair(3, 10);
            6'd10: f_taps = f_pair(2, 3);
            6'd11: f_taps = f_pair(3, 4);
            6'd12: f_taps = f_pair(5, 6);
            6'd13: f_taps = f_pair(6, 7);
            6'd14: f_taps = f_pair(7, 8);
            6'd15: f_taps = f_pair(8, 9);
            6'd16: f_taps = f_pair(9, 10);
            6'd17: f_taps = f_pair(1, 4);
            6'd18: f_taps = f_pair(2, 5);
            6'd19: f_taps = f_pair(3, 6);
            6'd20: f_taps = f_pair(4, 7);
            6'd21: f_taps = f_pair(5, 8);
            6'd22: f_taps = f_pair(6, 9);
            6'd23: f_taps = f_pair(1, 3);
            6'd24: f_taps = f_pair(4, 6);
            6'd25: f_taps = f_pair(5, 7);
            6'd26: f_taps = f_pair(6, 8);
            6'd27: f_taps = f_pair(7, 9);
            6'd28: f_taps = f_pair(8, 10);
            6'd29: f_taps = f_pair(1, 6);
            6'd30: f_taps = f_pair(2, 7);
            6'd31: f_taps = f_pair(3, 8);
            6'd32: f_taps = f_pair(4, 9);
            default: f_taps = '0;
        endcase
    endfunction

    // Stage 1: phase accumulators, Gold-code LFSRs, chip counter
    logic [PHASE_W-1:0] r_carr_ph, r_code_ph;
    logic [10:1]        r_g1, r_g2;
    logic [9:0]         r_chip_cnt;
    logic [5:0]         r_ca_sel1;
    logic [GAIN_W-1:0]  r_gain1;
    logic               r_dv1, r_tick1;
    logic [PHASE_W:0]   w_code_sum;
    logic               w_chip_tick, w_wrap, w_epoch, w_cur_bit;

    assign w_code_sum  = {1'b0, r_code_ph} + {1'b0, i_code_freq};
    assign w_chip_tick = w_code_sum[PHASE_W];
    assign w_wrap      = w_chip_tick && r_chip_cnt == 10'd1022;
    assign w_epoch     = i_dv_in && w_wrap;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_carr_ph  <= '0;
            r_code_ph  <= '0;
            r_chip_cnt <= '0;
            r_g1       <= '1;
            r_g2       <= '1;
            r_ca_sel1  <= '0;
            r_gain1    <= '0;
            r_dv1      <= 1'b0;
            r_tick1    <= 1'b0;
        end else begin
            r_dv1   <= i_dv_in;
            r_tick1 <= w_epoch;
            if (i_dv_in) begin
                r_carr_ph <= r_carr_ph + i_dop_freq;
                r_code_ph <= w_code_sum[PHASE_W-1:0];
                r_ca_sel1 <= i_ca_sel;
                r_gain1   <= i_gain;
                if (w_chip_tick) begin
                    r_chip_cnt <= w_wrap ? 10'd0 : r_chip_cnt + 10'd1;
                    r_g1       <= w_wrap ? '1 : {r_g1[9:1], r_g1[3] ^ r_g1[10]};
                    r_g2       <= w_wrap ? '1 : {r_g2[9:1], r_g2[2] ^ r_g2[3] ^ r_g2[6] ^ r_g2[8] ^ r_g2[9] ^ r_g2[10]};
                end
            end
        end
    end

`ifdef SV_CHAN_GEN_NAV_EN
    logic [4:0] r_epoch_cnt;
    logic       r_hold, r_nav_ready, r_underrun, r_cur_bit;
    logic       w_boundary, w_accept;

    assign w_boundary = w_epoch && r_epoch_cnt == 5'd19;
    assign w_accept   = i_nav_valid && r_nav_ready;

    // A boundary consumes the old holding contents before a same-cycle fill lands,
    // and that fill is enough to avoid flagging an underrun
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_epoch_cnt <= '0;
            r_hold      <= 1'b0;
            r_nav_ready <= 1'b1;
            r_underrun  <= 1'b0;
            r_cur_bit   <= 1'b0;
        end else begin
            if (w_epoch)
                r_epoch_cnt <= w_boundary ? 5'd0 : r_epoch_cnt + 5'd1;
            if (w_boundary)
                r_cur_bit <= !r_nav_ready && r_hold;
            if (w_boundary && r_nav_ready && !w_accept)
                r_underrun <= 1'b1;
            if (w_accept)
                r_hold <= i_nav_bit;
            r_nav_ready <= !w_accept && (r_nav_ready || w_boundary);
        end
    end

    assign w_cur_bit      = r_cur_bit;
    assign o_nav_ready    = r_nav_ready;
    assign o_nav_underrun = r_underrun;
`else
    logic w_unused_nav;

    assign w_unused_nav   = i_nav_bit ^ i_nav_valid;
    assign w_cur_bit      = 1'b0;
    assign o_nav_ready    = 1'b0;
    assign o_nav_underrun = 1'b0;
`endif

    // Stage 2: octant lookup, code/data sign and PRN mute
    logic [2:0]              w_oct;
    logic [10:1]             w_taps;
    logic                    w_neg;
    logic signed [NCO_W-1:0] w_re_mag, w_im_mag, w_re, w_im, r_re2, r_im2;
    logic [GAIN_W-1:0]       r_gain2;
    logic                    r_dv2, r_tick2;

    assign w_oct    = r_carr_ph[PHASE_W-1 -: 3];
    assign w_taps   = f_taps(r_ca_sel1);
    assign w_neg    = r_g1[10] ^ (^(r_g2 & w_taps)) ^ w_cur_bit;
    assign w_re_mag = (w_oct[1] ~^ w_oct[0]) ? W_C : W_S;
    assign w_im_mag = (w_oct[1] ^ w_oct[0]) ? W_C : W_S;
    assign w_re     = ~|w_taps ? '0 : (w_oct[2] ^ w_oct[1] ^ w_neg) ? -w_re_mag : w_re_mag;
    assign w_im     = ~|w_taps ? '0 : (w_oct[2] ^ w_neg) ? -w_im_mag : w_im_mag;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_re2   <= '0;
            r_im2   <= '0;
            r_gain2 <= '0;
            r_dv2   <= 1'b0;
            r_tick2 <= 1'b0;
        end else begin
            r_dv2   <= r_dv1;
            r_tick2 <= r_tick1;
            if (r_dv1) begin
                r_re2   <= w_re;
                r_im2   <= w_im;
                r_gain2 <= r_gain1;
            end
        end
    end

    // Stage 3: gain multiply, keep the top OUT_W bits (floor truncation)
    logic signed [PROD_W-1:0] w_re_prod, w_im_prod;
    logic signed [OUT_W-1:0]  r_real_out, r_imag_out;
    logic                     r_dv3, r_tick3;

    assign w_re_prod = PROD_W'(r_re2) * PROD_W'($signed({1'b0, r_gain2}));
    assign w_im_prod = PROD_W'(r_im2) * PROD_W'($signed({1'b0, r_gain2}));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_real_out <= '0;
            r_imag_out <= '0;
            r_dv3      <= 1'b0;
            r_tick3    <= 1'b0;
        end else begin
            r_dv3   <= r_dv2;
            r_tick3 <= r_tick2;
            if (r_dv2) begin
                r_real_out <= OUT_W'(w_re_prod >>> (PROD_W - OUT_W));
                r_imag_out <= OUT_W'(w_im_prod >>> (PROD_W - OUT_W));
            end
        end
    end

    assign o_dv_out     = r_dv3;
    assign o_epoch_tick = r_tick3;
    assign o_real_out   = r_real_out;
    assign o_imag_out   = r_imag_out;
endmodule

// File: tb/tb_sv_chan_gen.sv
// tb_sv_chan_gen: randomized self-checking bench for sv_chan_gen against a sample-level model
`timescale 1ns/1ps
module tb_sv_chan_gen;
    localparam int PHASE_W = 32;
    localparam int NCO_W   = 6;
    localparam int GAIN_W  = 16;
    localparam int OUT_W   = 16;
    localparam int SHIFT   = NCO_W + GAIN_W + 1 - OUT_W;
    localparam longint TWO_P = 64'd1 << PHASE_W;
    localparam real PI = 3.14159265358979;
    localparam real AMP = 2.0**(NCO_W-1) - 1.0;
    localparam int T1 [32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
    localparam int T2 [32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};
`ifdef SV_CHAN_GEN_NAV_EN
    localparam bit NAV = 1'b1;
`else
    localparam bit NAV = 1'b0;
`endif

    typedef struct {
        int     stamp;
        longint re;
        longint im;
        bit     tick;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic dv_in = 1'b0;
    logic nav_bit = 1'b0;
    logic nav_valid = 1'b0;
    logic [PHASE_W-1:0] dop_freq = '0;
    logic [PHASE_W-1:0] code_freq = '0;
    logic [GAIN_W-1:0] gain = '0;
    logic [5:0] ca_sel = '0;
    logic nav_ready, epoch_tick, nav_underrun, dv_out;
    logic signed [OUT_W-1:0] real_out, imag_out;

    sv_chan_gen #(.PHASE_W(PHASE_W), .NCO_W(NCO_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W)) dut (
        .i_clk(clk), .i_reset(reset), .i_dv_in(dv_in), .i_dop_freq(dop_freq),
        .i_code_freq(code_freq), .i_gain(gain), .i_ca_sel(ca_sel), .i_nav_bit(nav_bit),
        .i_nav_valid(nav_valid), .o_nav_ready(nav_ready), .o_epoch_tick(epoch_tick),
        .o_nav_underrun(nav_underrun), .o_dv_out(dv_out), .o_real_out(real_out),
        .o_imag_out(imag_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    exp_t q[$];
    longint obs_re[$], obs_im[$];
    bit obs_tick[$];
    longint hold_re, hold_im;
    bit gold [1:32][0:1022];
    longint m_carr, m_code;
    int m_chip, m_epoch;
    bit m_full, m_hold, m_cur, m_under;
    logic [9:0] pat = 10'b1100100000;

    task automatic chk(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic void build_gold();
        bit g1 [1:10];
        bit g2 [1:10];
        bit f1, f2;
        for (int p = 1; p <= 32; p++) begin
            for (int j = 1; j <= 10; j++) begin
                g1[j] = 1'b1;
                g2[j] = 1'b1;
            end
            for (int i = 0; i < 1023; i++) begin
                gold[p][i] = g1[10] ^ g2[T1[p-1]] ^ g2[T2[p-1]];
                f1 = g1[3] ^ g1[10];
                f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
                for (int j = 10; j >= 2; j--) begin
                    g1[j] = g1[j-1];
                    g2[j] = g2[j-1];
                end
                g1[1] = f1;
                g2[1] = f2;
            end
        end
    endfunction

    function automatic void model_reset();
        m_carr = 0;
        m_code = 0;
        m_chip = 0;
        m_epoch = 0;
        m_full = 0;
        m_hold = 0;
        m_cur = 0;
        m_under = 0;
    endfunction

    function automatic exp_t model_sample(input bit acc);
        exp_t e;
        int k, prn;
        longint re, im;
        e.tick = 0;
        m_carr = (m_carr + longint'(dop_freq)) % TWO_P;
        m_code = m_code + longint'(code_freq);
        if (m_code >= TWO_P) begin
            m_code = m_code - TWO_P;
            m_chip++;
            if (m_chip == 1023) begin
                m_chip = 0;
                e.tick = 1;
                m_epoch = (m_epoch + 1) % 20;
                if (NAV && m_epoch == 0) begin
                    m_cur = m_full ? m_hold : 1'b0;
                    if (!m_full && !acc) m_under = 1;
                    m_full = 0;
                end
            end
        end
        k = int'(m_carr >> (PHASE_W - 3));
        re = longint'($rtoi($floor(AMP * $cos(2.0 * PI * (k + 0.5) / 8.0) + 0.5)));
        im = longint'($rtoi($floor(AMP * $sin(2.0 * PI * (k + 0.5) / 8.0) + 0.5)));
        prn = int'(ca_sel);
        if (prn < 1 || prn > 32) begin
            re = 0;
            im = 0;
        end else if (gold[prn][m_chip] ^ m_cur) begin
            re = -re;
            im = -im;
        end
        e.re = (re * longint'(gain)) >>> SHIFT;
        e.im = (im * longint'(gain)) >>> SHIFT;
        e.stamp = cyc;
        return e;
    endfunction

    task automatic monitor();
        bit due;
        exp_t e;
        due = q.size() > 0 && q[0].stamp + 3 == cyc;
        if (dv_out || due) chk("dv_out_latency", dv_out, due);
        if (due) begin
            e = q.pop_front();
            chk("real_out", real_out, e.re);
            chk("imag_out", imag_out, e.im);
            chk("epoch_tick", epoch_tick, e.tick);
            hold_re = e.re;
            hold_im = e.im;
        end else begin
            chk("real_hold", real_out, hold_re);
            chk("imag_hold", imag_out, hold_im);
            chk("tick_idle", epoch_tick, 0);
        end
        if (dv_out) begin
            obs_re.push_back(real_out);
            obs_im.push_back(imag_out);
            obs_tick.push_back(epoch_tick);
        end
        chk("nav_ready", nav_ready, NAV ? !m_full : 1'b0);
        chk("nav_underrun", nav_underrun, NAV ? m_under : 1'b0);
    endtask

    task automatic step(input bit dv, input bit rst_in = 0, input bit nv = 0, input bit nb = 0);
        bit acc;
        dv_in = dv;
        reset = rst_in;
        nav_valid = nv;
        nav_bit = nb;
        if (!rst_in) begin
            acc = NAV && nv && !m_full;
            if (dv) q.push_back(model_sample(acc));
            if (acc) begin
                m_full = 1;
                m_hold = nb;
            end
        end
        @(posedge clk);
        cyc++;
        if (rst_in) begin
            q.delete();
            model_reset();
            hold_re = 0;
            hold_im = 0;
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic restart();
        step(0, 1);
        obs_re.delete();
        obs_im.delete();
        obs_tick.delete();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1);
        for (int i = 0; i < 5; i++) step(0);
    endtask

    task automatic check_prn1(input string tag, input int base, input bit inv);
        bit c;
        for (int i = 0; i < 10; i++) begin
            c = pat[9-i] ^ inv;
            chk({tag, "_re"}, obs_re[base+i], c ? -14848 : 14847);
            chk({tag, "_im"}, obs_im[base+i], c ? -6144 : 6143);
        end
    endtask

    initial begin
        int first_tick;
        build_gold();
        model_reset();
        hold_re = 0;
        hold_im = 0;
        ca_sel = 6'd1;
        gain = '1;
        code_freq = '1;
        restart();
        chk("rst_dv_out", dv_out, 0);
        chk("rst_real", real_out, 0);
        chk("rst_imag", imag_out, 0);
        chk("rst_nav_ready", nav_ready, NAV);

        // PRN 1 at one chip per sample after the first
        run(1100);
        chk("prn1_count", obs_re.size(), 1100);
        check_prn1("prn1", 0, 0);
        first_tick = -1;
        for (int i = 0; i < obs_tick.size(); i++)
            if (obs_tick[i] && first_tick < 0) first_tick = i;
        chk("first_epoch_idx", first_tick, 1023);

        // Randomized frequencies, gain, PRN and strobe pattern
        restart();
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                ca_sel = 6'($urandom_range(0, 40));
                dop_freq = $urandom;
                code_freq = $urandom | 32'h8000_0000;
            end
            gain = 16'($urandom);
            step($urandom_range(0, 3) != 0);
        end
        run(0);

        // Strobe gaps: one sample in seven cycles
        restart();
        ca_sel = 6'd5;
        dop_freq = 32'h1234_5678;
        code_freq = '1;
        gain = 16'h7A31;
        for (int i = 0; i < 200; i++) begin
            step(1);
            for (int j = 0; j < 6; j++) step(0);
        end
        run(0);
        chk("gap_count", obs_re.size(), 200);

        ca_sel = 6'd1;
        dop_freq = '0;
        gain = '1;
`ifdef SV_CHAN_GEN_NAV_EN
        // Bit 1 queued before the first boundary inverts the code from then on
        restart();
        step(0, 0, 1, 1);
        chk("nav_ready_after_push", nav_ready, 0);
        run(20 * 1023 + 20);
        chk("nav_count", obs_re.size(), 20 * 1023 + 20);
        chk("nav_boundary_tick", obs_tick[20 * 1023], 1);
        check_prn1("nav_pre", 0, 0);
        check_prn1("nav_inv", 20 * 1023, 1);
        chk("nav_ready_after_boundary", nav_ready, 1);
        chk("nav_no_underrun", nav_underrun, 0);

        // No bit offered: underrun sets and sticks; data bit falls back to 0
        restart();
        run(20 * 1023 + 20);
        chk("underrun_set", nav_underrun, 1);
        check_prn1("underrun_bit0", 20 * 1023, 0);
        run(100);
        chk("underrun_sticky", nav_underrun, 1);
        restart();
        chk("underrun_cleared", nav_underrun, 0);
`else
        restart();
        step(0, 0, 1, 1);
        run(50);
        chk("nav_ready_tied", nav_ready, 0);
        chk("nav_underrun_tied", nav_underrun, 0);
        check_prn1("nav_ignored", 0, 0);
`endif

        // Invalid PRN mutes the outputs while dv_out keeps pulsing
        restart();
        ca_sel = 6'd0;
        run(30);
        chk("mute_count", obs_re.size(), 30);
        for (int i = 0; i < 30; i++) begin
            chk("mute_re", obs_re[i], 0);
            chk("mute_im", obs_im[i], 0);
        end

        // Reset in mid-epoch with a full pipeline
        ca_sel = 6'd1;
        for (int i = 0; i < 500; i++) step(1);
        step(1, 1);
        chk("midrst_dv_out", dv_out, 0);
        chk("midrst_real", real_out, 0);
        chk("midrst_imag", imag_out, 0);
        chk("midrst_nav_ready", nav_ready, NAV);
        obs_re.delete();
        obs_im.delete();
        obs_tick.delete();
        run(12);
        chk("midrst_count", obs_re.size(), 12);
        check_prn1("midrst_restart", 0, 0);
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sv_chan_gen.md
# sv_chan_gen

Parametrised, self-contained GPS L1 C/A space-vehicle channel generator: carrier NCO, code NCO, on-chip Gold-code generator, 50 bps navigation-data modulation and gain scaling. It produces one complex baseband sample per input strobe. One instance per SV feeds the channel summer and noise adder upstream of the DAC path. Widths are generics, and code/nav epoch timing is exposed for the synthesizer controller.

## Interface
Parameters:
- PHASE_W, 32, width of carrier and code phase accumulators and frequency words
- NCO_W, 6, signed width of carrier samples
- GAIN_W, 16, unsigned gain width
- OUT_W, 16, signed output width; must satisfy OUT_W <= NCO_W+GAIN_W+1

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dv_in  in  1  sample strobe; all state advances only when high
- dop_freq  in  PHASE_W  (2^PHASE_W)*(Fdop/Fs), two's complement
- code_freq  in  PHASE_W  (2^PHASE_W)*(chip rate/Fs), unsigned
- gain  in  GAIN_W  unsigned amplitude
- ca_sel  in  6  PRN number 1..32; other values mute the channel
- nav_bit  in  1  next navigation data bit
- nav_valid  in  1  nav_bit offered
- nav_ready  out  1  holding register empty
- epoch_tick  out  1  one-cycle pulse at each 1 ms code epoch
- nav_underrun  out  1  sticky; a bit boundary found the holding register empty
- dv_out  out  1  output sample valid
- real_out  out  OUT_W  in-phase sample
- imag_out  out  OUT_W  quadrature sample

## Operation
- Carrier: on dv_in, carr_ph <= carr_ph + dop_freq (wraps).
  - Octant k = carr_ph[PHASE_W-1 -: 3].
  - Sample uses A = 2^(NCO_W-1)-1: real = round(A*cos(2π(k+0.5)/8)), imag = round(A*sin(2π(k+0.5)/8)).
  - These are elaboration-time constants; for NCO_W=6 they are ±29 and ±12.
- Code: on dv_in, code_ph <= code_ph + code_freq. A carry out is a chip tick.
  - On a chip tick, G1 (x^10+x^3+1) and G2 (x^10+x^9+x^8+x^6+x^3+x^2+1) shift once and chip_cnt increments.
  - At chip_cnt 1022 it wraps to 0, both LFSRs reload to all-ones and epoch_tick pulses.
  - The chip is G1[10] XOR (G2 tap pair per ca_sel, per IS-GPS-200 table).
  - A sample uses the chip value after that sample's update.
- Nav:
  - epoch_cnt counts epochs 0..19.
  - At the wrap from 19 to 0 (bit boundary), cur_bit <= hold and the holding register empties.
  - If the holding register is empty at the boundary, cur_bit <= 0 and nav_underrun sets.
  - Accepting a bit on nav_valid&&nav_ready fills the holding register; nav_ready = !full.
  - A fill and a boundary in the same cycle: the boundary consumes the old contents first, then the new bit fills the register; no underrun.
- Modulation: sign = chip XOR cur_bit. Sign 1 negates both carrier samples. An invalid ca_sel forces the samples to 0.
- Scaling: product = signed(sample) * signed({1'b0,gain}), NCO_W+GAIN_W+1 bits wide. Each output is the top OUT_W bits of the product, arithmetically truncated with no rounding.
- ca_sel, dop_freq, code_freq and gain are sampled every dv_in cycle; there is no shadowing.
- Reset:
  - Accumulators, chip_cnt, epoch_cnt, cur_bit and nav_underrun clear to 0.
  - The LFSRs load all-ones and the holding register empties.
  - dv_out, epoch_tick, real_out and imag_out go to 0; nav_ready goes to 1.
  - Reset mid-sample discards all pipeline contents.

## Timing
- Three-stage pipeline:
  1. Accumulators, LFSRs and counters register.
  2. LUT lookup and sign application register.
  3. Multiply registers.
- dv_in at cycle n gives dv_out=1 at n+3.
- real_out and imag_out hold their value until the next dv_out.
- epoch_tick is aligned with dv_out of the first sample of the new epoch.
- With dv_in low, no state changes; gaps of any length are legal.
- nav_ready is registered; the first bit is accepted in the cycle after reset release.

## Configuration
- SV_CHAN_GEN_NAV_EN defined: nav data modulation and handshake behave as described above.
- Without SV_CHAN_GEN_NAV_EN:
  - cur_bit is constant 0 and nav_ready and nav_underrun are tied 0.
  - nav_bit and nav_valid are ignored.
  - Epoch counting and epoch_tick remain.
  - Hold register and epoch_cnt logic are removed.

## Test plan
- Code sequence and scaling: PRN 1, code_freq=2^32-1 (wrap tolerance off: use PHASE_W=32, code_freq=0xFFFFFFFF plus a preloaded phase), dop_freq=0, gain=0xFFFF, macro off.
  - First 10 chips are 1100100000.
  - real_out is -14848 for chip 1 and +14847 for chip 0; imag_out is -6144/+6143.
- Epoch: code_freq giving one chip per sample → epoch_tick pulses every 1023 dv_in samples.
  - The chip sequence repeats exactly across epochs.
- Nav modulation: push nav_bit=1 before the first boundary.
  - After 20 epochs, output signs invert relative to the code-only reference.
  - nav_ready rises in the boundary cycle.
- Underrun: no bit pushed → nav_underrun=1 at the first boundary and stays high until reset. Outputs then use bit 0.
- Strobe gaps: dv_in toggles 1-of-7 cycles.
  - Output samples are identical to the continuous dv_in run.
  - dv_out appears exactly 3 cycles after each dv_in.
- Invalid PRN and reset: ca_sel=0 gives outputs 0 with dv_out still pulsing.
  - Reset mid-epoch → every output is 0 next cycle, nav_ready=1, and the chip sequence restarts from chip 0.
